game_board_ctrl: RTL and testbench

Parametrised successor to the fixed 10x10 two-player ship board. It holds an N x N cell array per player and runs the game phase sequence itself: host placement, guest placement, alternating shots, game over. It checks every command and answers with a registered result code. It sits between the mouse/UART command path and the VGA board renderers, and gives each renderer its own registered read port.

---
 rtl/game_pkg.sv | 28 ++
 rtl/game_board_bank.sv | 65 ++++++
 rtl/game_board_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_game_board_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types for the two-player ship board: cell, phase and response codes.
// Latency: n/a (types only).
// Backpressure: n/a.
package game_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_SHIP  = 2'b01,
        CELL_HIT   = 2'b10,
        CELL_MISS  = 2'b11
    } cell_t;

    typedef enum logic [2:0] {
        PH_IDLE        = 3'd0,
        PH_PLACE_HOST  = 3'd1,
        PH_PLACE_GUEST = 3'd2,
        PH_PLAY        = 3'd3,
        PH_GAME_OVER   = 3'd4
    } phase_t;

    typedef enum logic [1:0] {
        RSP_REJECT = 2'b00,
        RSP_PLACED = 2'b01,
        RSP_HIT    = 2'b10,
        RSP_MISS   = 2'b11
    } rsp_t;

endpackage

// File: rtl/game_board_bank.sv
// One player's BOARD_N x BOARD_N cell array: combinational lookup, one write port, display read port.
// Latency: lookup 0 cycles, display read 1 cycle (pre-write value on a same-edge write).
// Backpressure: none; writes and reads are accepted every cycle.
module game_board_bank
    import game_pkg::*;
#(
    parameter int BOARD_N = 10,
    parameter int COORD_W = $clog2(BOARD_N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic [COORD_W-1:0] lk_x,
    input  logic [COORD_W-1:0] lk_y,
    output cell_t              lk_code,
    input  logic               wr_en,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  cell_t              wr_code,
    input  logic [COORD_W-1:0] rd_x,
    input  logic [COORD_W-1:0] rd_y,
    output cell_t              rd_code
);

    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int IDX_W = $clog2(CELLS);

    function automatic logic in_range(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return ({1'b0, x} < (COORD_W+1)'(BOARD_N)) && ({1'b0, y} < (COORD_W+1)'(BOARD_N));
    endfunction

    // Row-major flattening; only meaningful when in_range() holds.
    function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        int idx;
        idx = int'(y) * BOARD_N + int'(x);
        return idx[IDX_W-1:0];
    endfunction

    cell_t cells [CELLS];

    // Command-address lookup; out-of-range addresses read as EMPTY.
    always_comb begin
        lk_code = CELL_EMPTY;
        if (in_range(lk_x, lk_y)) lk_code = cells[cell_idx(lk_x, lk_y)];
    end

    // Cell array: clear on new game, otherwise single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CELLS; i++) cells[i] <= CELL_EMPTY;
        end else if (clr) begin
            for (int i = 0; i < CELLS; i++) cells[i] <= CELL_EMPTY;
        end else if (wr_en && in_range(wr_x, wr_y)) begin
            cells[cell_idx(wr_x, wr_y)] <= wr_code;
        end
    end

    // Registered display read with out-of-range masking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                rd_code <= CELL_EMPTY;
        else if (in_range(rd_x, rd_y)) rd_code <= cells[cell_idx(rd_x, rd_y)];
        else                       rd_code <= CELL_EMPTY;
    end

endmodule

// File: rtl/game_board_ctrl.sv
// Two-player ship board: phase sequencing, command checking, counters, per-player display read ports.
// Latency: response 1 cycle after cmd_valid; display read 1 cycle. Optional macro BONUS_SHOT_ON_HIT_EN.
// Backpressure: none; every command is accepted and answered (start in the same cycle drops it).
module game_board_ctrl
    import game_pkg::*;
#(
    parameter  int BOARD_N    = 10,
    parameter  int SHIP_CELLS = 4,
    localparam int COORD_W    = $clog2(BOARD_N),
    localparam int CNT_W      = $clog2(SHIP_CELLS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cmd_valid,
    input  logic               cmd_player,
    input  logic [COORD_W-1:0] cmd_x,
    input  logic [COORD_W-1:0] cmd_y,
    output logic               rsp_valid,
    output logic [1:0]         rsp_code,
    output logic [2:0]         phase,
    output logic               turn,
    output logic               winner,
    output logic [CNT_W-1:0]   left_host,
    output logic [CNT_W-1:0]   left_guest,
    input  logic [COORD_W-1:0] rd_x_host,
    input  logic [COORD_W-1:0] rd_y_host,
    input  logic [COORD_W-1:0] rd_x_guest,
    input  logic [COORD_W-1:0] rd_y_guest,
    output logic [1:0]         rd_code_host,
    output logic [1:0]         rd_code_guest
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SHIP_CELLS);

    phase_t           phase_q, phase_d;
    logic             turn_q, turn_d;
    logic             winner_q, winner_d;
    logic [CNT_W-1:0] left_host_q, left_host_d;
    logic [CNT_W-1:0] left_guest_q, left_guest_d;
    logic             rsp_valid_q, rsp_valid_d;
    rsp_t             rsp_code_q, rsp_code_d;

    cell_t host_lk, guest_lk, host_rd, guest_rd, wr_code;
    logic  wr_host, wr_guest, clr;
    logic  cmd_in_range;
    cell_t shot_cell;
    logic [CNT_W-1:0] opp_left;

    assign cmd_in_range = ({1'b0, cmd_x} < (COORD_W+1)'(BOARD_N)) &&
                          ({1'b0, cmd_y} < (COORD_W+1)'(BOARD_N));
    // A shot always lands on the board of the player who is not on turn.
    assign shot_cell = turn_q ? host_lk : guest_lk;
    assign opp_left  = turn_q ? left_host_q : left_guest_q;

    game_board_bank #(.BOARD_N(BOARD_N), .COORD_W(COORD_W)) u_host_bank (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .lk_x(cmd_x), .lk_y(cmd_y), .lk_code(host_lk),
        .wr_en(wr_host), .wr_x(cmd_x), .wr_y(cmd_y), .wr_code(wr_code),
        .rd_x(rd_x_host), .rd_y(rd_y_host), .rd_code(host_rd)
    );

    game_board_bank #(.BOARD_N(BOARD_N), .COORD_W(COORD_W)) u_guest_bank (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .lk_x(cmd_x), .lk_y(cmd_y), .lk_code(guest_lk),
        .wr_en(wr_guest), .wr_x(cmd_x), .wr_y(cmd_y), .wr_code(wr_code),
        .rd_x(rd_x_guest), .rd_y(rd_y_guest), .rd_code(guest_rd)
    );

    // Next-state, command checking and board writes.
    always_comb begin
        phase_d      = phase_q;
        turn_d       = turn_q;
        winner_d     = winner_q;
        left_host_d  = left_host_q;
        left_guest_d = left_guest_q;
        rsp_valid_d  = 1'b0;
        rsp_code_d   = RSP_REJECT;
        wr_host      = 1'b0;
        wr_guest     = 1'b0;
        wr_code      = CELL_SHIP;
        clr          = 1'b0;

        if (start) begin
            phase_d      = PH_PLACE_HOST;
            turn_d       = 1'b0;
            winner_d     = 1'b0;
            left_host_d  = '0;
            left_guest_d = '0;
            clr          = 1'b1;
        end else if (cmd_valid) begin
            rsp_valid_d = 1'b1;
            if (cmd_in_range) begin
                case (phase_q)
                    PH_PLACE_HOST: begin
                        if (!cmd_player && host_lk == CELL_EMPTY && left_host_q < CNT_FULL) begin
                            wr_host     = 1'b1;
                            left_host_d = left_host_q + CNT_ONE;
                            rsp_code_d  = RSP_PLACED;
                            if (left_host_q == CNT_FULL - CNT_ONE) phase_d = PH_PLACE_GUEST;
                        end
                    end
                    PH_PLACE_GUEST: begin
                        if (cmd_player && guest_lk == CELL_EMPTY && left_guest_q < CNT_FULL) begin
                            wr_guest     = 1'b1;
                            left_guest_d = left_guest_q + CNT_ONE;
                            rsp_code_d   = RSP_PLACED;
                            if (left_guest_q == CNT_FULL - CNT_ONE) begin
                                phase_d = PH_PLAY;
                                turn_d  = 1'b0;
                            end
                        end
                    end
                    PH_PLAY: begin
                        if (cmd_player == turn_q) begin
                            if (shot_cell == CELL_SHIP && opp_left != '0) begin
                                wr_host    = turn_q;
                                wr_guest   = !turn_q;
                                wr_code    = CELL_HIT;
                                rsp_code_d = RSP_HIT;
                                if (turn_q) left_host_d  = left_host_q - CNT_ONE;
                                else        left_guest_d = left_guest_q - CNT_ONE;
                                if (opp_left == CNT_ONE) begin
                                    phase_d  = PH_GAME_OVER;
                                    winner_d = turn_q;
                                end else begin
`ifdef BONUS_SHOT_ON_HIT_EN
                                    turn_d = turn_q;
`else
                                    turn_d = !turn_q;
`endif
                                end
                            end else if (shot_cell == CELL_EMPTY) begin
                                wr_host    = turn_q;
                                wr_guest   = !turn_q;
                                wr_code    = CELL_MISS;
                                rsp_code_d = RSP_MISS;
                                turn_d     = !turn_q;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Phase, turn, winner, counters and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= PH_IDLE;
            turn_q       <= 1'b0;
            winner_q     <= 1'b0;
            left_host_q  <= '0;
            left_guest_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_code_q   <= RSP_REJECT;
        end else begin
            phase_q      <= phase_d;
            turn_q       <= turn_d;
            winner_q     <= winner_d;
            left_host_q  <= left_host_d;
            left_guest_q <= left_guest_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_code_q   <= rsp_code_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_code      = rsp_code_q;
    assign phase         = phase_q;
    assign turn          = turn_q;
    assign winner        = winner_q;
    assign left_host     = left_host_q;
    assign left_guest    = left_guest_q;
    assign rd_code_host  = host_rd;
    assign rd_code_guest = guest_rd;

endmodule

// File: tb/tb_game_board_ctrl.sv
// Scoreboard bench for game_board_ctrl: directed game script, expected responses queued, monitor compares.
// Latency: responses expected one cycle after each issued command.
// Backpressure: none modelled; commands are issued one every two cycles.
module tb_game_board_ctrl;

    localparam logic [1:0] R_REJ = 2'b00, R_PLC = 2'b01, R_HIT = 2'b10, R_MIS = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_player = 1'b0;
    logic [3:0] cmd_x = '0, cmd_y = '0;
    logic       rsp_valid;
    logic [1:0] rsp_code;
    logic [2:0] phase;
    logic       turn, winner;
    logic [2:0] left_host, left_guest;
    logic [3:0] rd_x_host = '0, rd_y_host = '0, rd_x_guest = '0, rd_y_guest = '0;
    logic [1:0] rd_code_host, rd_code_guest;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    game_board_ctrl #(.BOARD_N(10), .SHIP_CELLS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid),
        .cmd_player(cmd_player), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .rsp_valid(rsp_valid), .rsp_code(rsp_code), .phase(phase), .turn(turn),
        .winner(winner), .left_host(left_host), .left_guest(left_guest),
        .rd_x_host(rd_x_host), .rd_y_host(rd_y_host),
        .rd_x_guest(rd_x_guest), .rd_y_guest(rd_y_guest),
        .rd_code_host(rd_code_host), .rd_code_guest(rd_code_guest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every response strobe must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        logic [1:0] e;
        if (rst_n && rsp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got code %0d with nothing expected", rsp_code);
            end else begin
                e = exp_q.pop_front();
                if (rsp_code !== e) begin
                    errors++;
                    $display("FAIL rsp_code: got %0d expected %0d", rsp_code, e);
                end
            end
        end
    end

    task automatic send(input logic p, input int x, input int y, input logic [1:0] exp);
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        cmd_player = p;
        cmd_x      = 4'(x);
        cmd_y      = 4'(y);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        check("rst_phase", phase, 0);
        check("rst_turn", turn, 0);
        check("rst_winner", winner, 0);
        check("rst_left_host", left_host, 0);
        check("rst_left_guest", left_guest, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_code", rsp_code, 0);
        check("rst_rd_host", rd_code_host, 0);
        rst_n = 1'b1;

        // Command in IDLE is rejected
        send(0, 0, 0, R_REJ);
        check("idle_phase", phase, 0);

        pulse_start();
        check("start_phase", phase, 1);

        // Host placement with rejects in between
        send(0, 0, 0, R_PLC);
        send(0, 1, 0, R_PLC);
        send(0, 2, 0, R_PLC);
        check("place3_left", left_host, 3);
        check("place3_phase", phase, 1);
        send(0, 0, 0, R_REJ);   // occupied
        send(1, 5, 5, R_REJ);   // guest during host placement
        send(0, 10, 0, R_REJ);  // x out of range
        check("rej_left_host", left_host, 3);
        check("rej_left_guest", left_guest, 0);
        check("rej_phase", phase, 1);
        send(0, 3, 0, R_PLC);
        check("place4_left", left_host, 4);
        check("place4_phase", phase, 2);

        // Guest placement
        rd_x_guest = 4'd9; rd_y_guest = 4'd9;
        send(1, 9, 9, R_PLC);
        send(1, 8, 9, R_PLC);
        send(1, 7, 9, R_PLC);
        send(0, 6, 9, R_REJ);   // host during guest placement
        send(1, 6, 9, R_PLC);
        check("guest_left", left_guest, 4);
        check("play_phase", phase, 3);
        check("play_turn", turn, 0);
        check("rd_guest_ship", rd_code_guest, 1);

`ifdef BONUS_SHOT_ON_HIT_EN
        send(0, 9, 9, R_HIT);
        check("bonus_hit_left", left_guest, 3);
        check("bonus_hit_turn", turn, 0);
        send(0, 0, 5, R_MIS);
        check("bonus_miss_turn", turn, 1);
        rd_x_host = 4'd5; rd_y_host = 4'd5;
        send(1, 5, 5, R_MIS);
        check("rd_host_before", rd_code_host, 0);
        @(posedge clk); #1;
        check("rd_host_after", rd_code_host, 3);
        send(0, 8, 9, R_HIT);
        send(0, 7, 9, R_HIT);
        check("bonus_left1", left_guest, 1);
        check("bonus_turn_held", turn, 0);
        send(0, 6, 9, R_HIT);
`else
        send(0, 9, 9, R_HIT);
        check("hit_left_guest", left_guest, 3);
        check("hit_turn", turn, 1);
        send(0, 8, 9, R_REJ);   // not host's turn
        check("rej_turn", turn, 1);
        check("rej_left_guest2", left_guest, 3);
        check("rd_guest_hit", rd_code_guest, 2);
        rd_x_host = 4'd5; rd_y_host = 4'd5;
        send(1, 5, 5, R_MIS);
        check("rd_host_before", rd_code_host, 0);
        check("miss_turn", turn, 0);
        @(posedge clk); #1;
        check("rd_host_after", rd_code_host, 3);
        send(0, 0, 5, R_MIS);
        send(1, 5, 5, R_REJ);   // already MISS
        check("rej_repeat_turn", turn, 1);
        send(1, 0, 0, R_HIT);
        check("guest_hit_left", left_host, 3);
        check("guest_hit_turn", turn, 0);
        send(0, 8, 9, R_HIT);
        send(1, 1, 1, R_MIS);
        send(0, 7, 9, R_HIT);
        check("left1", left_guest, 1);
        send(1, 2, 2, R_MIS);
        rd_x_guest = 4'd12;
        @(posedge clk); #1;
        check("rd_guest_oor", rd_code_guest, 0);
        send(0, 6, 9, R_HIT);
`endif
        check("go_phase", phase, 4);
        check("go_winner", winner, 0);
        check("go_left_guest", left_guest, 0);
        check("go_turn", turn, 0);
        send(0, 1, 1, R_REJ);
        send(1, 1, 1, R_REJ);
        check("go_phase_held", phase, 4);

        // New game clears everything
        rd_x_host = 4'd0; rd_y_host = 4'd0;
        pulse_start();
        check("restart_phase", phase, 1);
        check("restart_left_host", left_host, 0);
        check("restart_left_guest", left_guest, 0);
        @(posedge clk); #1;
        check("restart_rd_host", rd_code_host, 0);

        // start beats a simultaneous command
        @(posedge clk); #1;
        start = 1'b1; cmd_valid = 1'b1; cmd_player = 1'b0; cmd_x = 4'd1; cmd_y = 4'd1;
        @(posedge clk); #1;
        start = 1'b0; cmd_valid = 1'b0;
        check("drop_rsp_valid", rsp_valid, 0);
        check("drop_left_host", left_host, 0);

        // Refill to PLAY, then async reset mid-game
        for (int i = 0; i < 4; i++) send(0, i, 2, R_PLC);
        for (int i = 0; i < 4; i++) send(1, i, 3, R_PLC);
        check("refill_phase", phase, 3);
        rd_x_host = 4'd0; rd_y_host = 4'd2;
        send(0, 0, 0, R_MIS);
        check("pre_rst_turn", turn, 1);
        check("pre_rst_rd_host", rd_code_host, 1);
        #6;
        rst_n = 1'b0;
        #1;
        check("arst_phase", phase, 0);
        check("arst_turn", turn, 0);
        check("arst_left_host", left_host, 0);
        check("arst_left_guest", left_guest, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_rsp_code", rsp_code, 0);
        check("arst_rd_host", rd_code_host, 0);
        check("arst_winner", winner, 0);
        #10;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
